// File: rtl/branch_predictor_pkg.sv
// Shared types and helpers for the gshare branch predictor.
//   cnt_t      : 2-bit saturating prediction counter
//   CNT_*      : named counter states (strong/weak not-taken, weak/strong taken)
//   sat_step() : one saturating increment (up=1) or decrement (up=0)
package branch_predictor_pkg;

    typedef logic [1:0] cnt_t;

    localparam cnt_t CNT_SNT = 2'b00;
    localparam cnt_t CNT_WNT = 2'b01;
    localparam cnt_t CNT_WT  = 2'b10;
    localparam cnt_t CNT_ST  = 2'b11;

    function automatic cnt_t sat_step(input cnt_t c, input logic up);
        cnt_t r;
        r = c;
        if (up) begin
            if (c != CNT_ST) begin
                r = c + 2'd1;
            end
        end else begin
            if (c != CNT_SNT) begin
                r = c - 2'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter32.sv
// 32-bit saturating event counter.
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset, clears the count
//   i_en    : count one event this cycle
//   o_cnt   : current count, sticks at 32'hFFFF_FFFF
module sat_counter32 (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    output logic [31:0] o_cnt
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_en && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt = cnt_q;

endmodule

// File: rtl/branch_predictor.sv
// gshare conditional-branch predictor.
// Lookup in ID (combinational): index = PC[INDEX_W+1:2] ^ ghr, predicts taken
// when the indexed 2-bit counter's MSB is set. Resolution in EX (combinational):
// flags a mispredict and supplies the corrected fetch PC. Counter table, global
// history and statistics update only when a valid branch leaves EX.
//   i_clk, i_rst_n                 : clock, asynchronous active-low reset
//   i_id_pc, i_id_is_br            : ID-stage lookup request
//   o_is_pred_need_br, o_id_pred_idx : prediction and index carried down the pipe
//   i_ex_*                         : resolved branch information from EX
//   o_is_pred_wrong, o_redirect_pc : mispredict request and corrected PC
//   o_br_cnt, o_miss_cnt           : saturating statistics
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int   INDEX_W = 6,
    parameter int   GHR_W   = 4,
    parameter cnt_t CNT_RST = CNT_WNT
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [31:0]        i_id_pc,
    input  logic               i_id_is_br,
    output logic               o_is_pred_need_br,
    output logic [INDEX_W-1:0] o_id_pred_idx,
    input  logic               i_ex_br_valid,
    input  logic               i_ex_adv,
    input  logic               i_ex_taken,
    input  logic               i_ex_pred_taken,
    input  logic [INDEX_W-1:0] i_ex_pred_idx,
    input  logic [31:0]        i_ex_pc,
    input  logic [31:0]        i_ex_target,
    output logic               o_is_pred_wrong,
    output logic [31:0]        o_redirect_pc,
    output logic [31:0]        o_br_cnt,
    output logic [31:0]        o_miss_cnt
);

    localparam int ENTRIES = 1 << INDEX_W;

    cnt_t             cnt_q [ENTRIES];
    cnt_t             cnt_d [ENTRIES];
    logic [GHR_W-1:0] ghr_q;
    logic [GHR_W-1:0] ghr_d;
    logic [INDEX_W-1:0] idx;
    logic             upd;

    // Lookup reads registered state only, so a same-cycle update is not bypassed.
    assign idx               = i_id_pc[INDEX_W+1:2] ^ INDEX_W'(ghr_q);
    assign o_id_pred_idx     = idx;
    assign o_is_pred_need_br = i_id_is_br & cnt_q[idx][1];

    // Qualifying with the advance strobe makes a stalled branch resolve once.
    assign upd             = i_ex_br_valid & i_ex_adv;
    assign o_is_pred_wrong = upd & (i_ex_taken != i_ex_pred_taken);
    assign o_redirect_pc   = i_ex_taken ? i_ex_target : (i_ex_pc + 32'd4);

    always_comb begin
        cnt_d = cnt_q;
        if (upd) begin
            cnt_d[i_ex_pred_idx] = sat_step(cnt_q[i_ex_pred_idx], i_ex_taken);
        end
    end

    // A one-bit history has no older bits to shift, so it needs its own form.
    generate
        if (GHR_W == 1) begin : g_ghr_one
            always_comb begin
                ghr_d = ghr_q;
                if (upd) begin
                    ghr_d = i_ex_taken;
                end
            end
        end else begin : g_ghr_shift
            always_comb begin
                ghr_d = ghr_q;
                if (upd) begin
                    ghr_d = {ghr_q[GHR_W-2:0], i_ex_taken};
                end
            end
        end
    endgenerate

    // Table is a flop array so every entry can be cleared asynchronously.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= CNT_RST;
            end
            ghr_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            ghr_q <= ghr_d;
        end
    end

    sat_counter32 u_br_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (upd),
        .o_cnt   (o_br_cnt)
    );

    sat_counter32 u_miss_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (o_is_pred_wrong),
        .o_cnt   (o_miss_cnt)
    );

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [31:0] i_id_pc = '0;
    logic        i_id_is_br = 1'b0;
    logic        o_is_pred_need_br;
    logic [5:0]  o_id_pred_idx;
    logic        i_ex_br_valid = 1'b0;
    logic        i_ex_adv = 1'b0;
    logic        i_ex_taken = 1'b0;
    logic        i_ex_pred_taken = 1'b0;
    logic [5:0]  i_ex_pred_idx = '0;
    logic [31:0] i_ex_pc = '0;
    logic [31:0] i_ex_target = '0;
    logic        o_is_pred_wrong;
    logic [31:0] o_redirect_pc;
    logic [31:0] o_br_cnt;
    logic [31:0] o_miss_cnt;

    int total = 0;
    int bad = 0;

    // Reference model: plain integers for counter strength (0..3), history as
    // an integer kept modulo 16, and event tallies.
    int      m_cnt [64];
    int      m_ghr;
    longint  m_br;
    longint  m_miss;

    always #5 i_clk = ~i_clk;

    branch_predictor #(.INDEX_W(6), .GHR_W(4), .CNT_RST(2'b01)) dut (
        .i_clk             (i_clk),
        .i_rst_n           (i_rst_n),
        .i_id_pc           (i_id_pc),
        .i_id_is_br        (i_id_is_br),
        .o_is_pred_need_br (o_is_pred_need_br),
        .o_id_pred_idx     (o_id_pred_idx),
        .i_ex_br_valid     (i_ex_br_valid),
        .i_ex_adv          (i_ex_adv),
        .i_ex_taken        (i_ex_taken),
        .i_ex_pred_taken   (i_ex_pred_taken),
        .i_ex_pred_idx     (i_ex_pred_idx),
        .i_ex_pc           (i_ex_pc),
        .i_ex_target       (i_ex_target),
        .o_is_pred_wrong   (o_is_pred_wrong),
        .o_redirect_pc     (o_redirect_pc),
        .o_br_cnt          (o_br_cnt),
        .o_miss_cnt        (o_miss_cnt)
    );

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_cnt[i] = 1;
        m_ghr  = 0;
        m_br   = 0;
        m_miss = 0;
    endtask

    function automatic int exp_idx(input logic [31:0] pc);
        return ((int'(pc) >>> 2) & 63) ^ m_ghr;
    endfunction

    function automatic logic exp_pred(input logic [31:0] pc, input logic br);
        return br && (m_cnt[exp_idx(pc)] >= 2);
    endfunction

    function automatic logic [31:0] exp_redirect();
        longint t;
        if (i_ex_taken) return i_ex_target;
        t = (longint'(i_ex_pc) + 4) % 64'h1_0000_0000;
        return t[31:0];
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_clock();
        int k;
        if (i_rst_n && i_ex_br_valid && i_ex_adv) begin
            k = int'(i_ex_pred_idx);
            if (i_ex_taken) m_cnt[k] = (m_cnt[k] == 3) ? 3 : m_cnt[k] + 1;
            else            m_cnt[k] = (m_cnt[k] == 0) ? 0 : m_cnt[k] - 1;
            m_ghr = ((m_ghr * 2) + (i_ex_taken ? 1 : 0)) % 16;
            if (m_br < 64'hFFFF_FFFF) m_br++;
            if (i_ex_taken != i_ex_pred_taken && m_miss < 64'hFFFF_FFFF) m_miss++;
        end
    endtask

    // Clock edge, model update, then settle 1 time unit past the edge.
    task automatic tick();
        @(posedge i_clk);
        model_clock();
        #1;
    endtask

    task automatic drive_ex(input logic bv, input logic adv, input logic tk,
                            input logic ptk, input logic [5:0] pidx,
                            input logic [31:0] pc, input logic [31:0] tgt);
        i_ex_br_valid   = bv;
        i_ex_adv        = adv;
        i_ex_taken      = tk;
        i_ex_pred_taken = ptk;
        i_ex_pred_idx   = pidx;
        i_ex_pc         = pc;
        i_ex_target     = tgt;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        model_reset();
        drive_ex(0, 0, 0, 0, 6'h00, 32'h0, 32'h0);
        i_id_is_br = 1'b1;
        i_id_pc    = 32'h100;
        #3;
        total++;
        if (o_is_pred_need_br !== 1'b0) begin
            bad++; $display("FAIL reset_pred got=%0b want=0", o_is_pred_need_br);
        end
        total++;
        if (o_id_pred_idx !== 6'h00) begin
            bad++; $display("FAIL reset_idx got=%h want=00", o_id_pred_idx);
        end
        total++;
        if (o_br_cnt !== 32'd0 || o_miss_cnt !== 32'd0) begin
            bad++; $display("FAIL reset_stats got br=%0d miss=%0d want 0/0", o_br_cnt, o_miss_cnt);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();
        $display("reset: pred=%0b idx=%h", o_is_pred_need_br, o_id_pred_idx);
    endtask

    task automatic test_training();
        logic [31:0] pc;
        for (int n = 0; n < 3; n++) begin
            drive_ex(1, 1, 1, 1, 6'h05, 32'h0, 32'h0);
            tick();
            $display("train %0d: cnt5 model=%0d", n, m_cnt[5]);
        end
        drive_ex(0, 0, 0, 0, 6'h00, 32'h0, 32'h0);
        pc = 32'((5 ^ m_ghr) << 2);
        i_id_pc    = pc;
        i_id_is_br = 1'b1;
        #3;
        total++;
        if (o_id_pred_idx !== 6'h05) begin
            bad++; $display("FAIL train_idx got=%h want=05", o_id_pred_idx);
        end
        total++;
        if (o_is_pred_need_br !== 1'b1) begin
            bad++; $display("FAIL train_pred got=%0b want=1", o_is_pred_need_br);
        end
        // Saturation: one not-taken step from 11 must still predict taken.
        drive_ex(1, 1, 0, 1, 6'h05, 32'h0, 32'h0);
        tick();
        drive_ex(0, 0, 0, 0, 6'h00, 32'h0, 32'h0);
        i_id_pc = 32'((5 ^ m_ghr) << 2);
        #3;
        total++;
        if (o_is_pred_need_br !== exp_pred(i_id_pc, 1'b1) || o_is_pred_need_br !== 1'b1) begin
            bad++; $display("FAIL train_sat got=%0b want=1", o_is_pred_need_br);
        end
        tick();
    endtask

    task automatic test_mispredict();
        longint miss0;
        miss0 = m_miss;
        drive_ex(1, 1, 0, 1, 6'h11, 32'h200, 32'h900);
        #3;
        total++;
        if (o_is_pred_wrong !== 1'b1) begin
            bad++; $display("FAIL misp_wrong got=%0b want=1", o_is_pred_wrong);
        end
        total++;
        if (o_redirect_pc !== 32'h204) begin
            bad++; $display("FAIL misp_redirect got=%h want=00000204", o_redirect_pc);
        end
        tick();
        drive_ex(0, 0, 0, 0, 6'h00, 32'h0, 32'h0);
        #3;
        total++;
        if (o_miss_cnt !== 32'(miss0 + 1)) begin
            bad++; $display("FAIL misp_count got=%0d want=%0d", o_miss_cnt, miss0 + 1);
        end
        $display("mispredict: redirect=%h miss=%0d", 32'h204, o_miss_cnt);
        tick();
    endtask

    task automatic test_stall();
        longint br0;
        br0 = m_br;
        for (int n = 0; n < 3; n++) begin
            drive_ex(1, 0, 1, 0, 6'h22, 32'h300, 32'h80);
            #3;
            total++;
            if (o_is_pred_wrong !== 1'b0) begin
                bad++; $display("FAIL stall_hold%0d got=%0b want=0", n, o_is_pred_wrong);
            end
            tick();
        end
        drive_ex(1, 1, 1, 0, 6'h22, 32'h300, 32'h80);
        #3;
        total++;
        if (o_is_pred_wrong !== 1'b1 || o_redirect_pc !== 32'h80) begin
            bad++; $display("FAIL stall_adv got wrong=%0b pc=%h want 1/00000080", o_is_pred_wrong, o_redirect_pc);
        end
        tick();
        drive_ex(0, 0, 0, 0, 6'h00, 32'h0, 32'h0);
        #3;
        total++;
        if (o_br_cnt !== 32'(br0 + 1)) begin
            bad++; $display("FAIL stall_brcnt got=%0d want=%0d", o_br_cnt, br0 + 1);
        end
        $display("stall: br=%0d", o_br_cnt);
        tick();
    endtask

    task automatic test_history();
        logic [3:0] pat;
        pat = 4'b1011;
        for (int n = 3; n >= 0; n--) begin
            drive_ex(1, 1, pat[n], pat[n], 6'h3F, 32'h0, 32'h0);
            tick();
        end
        drive_ex(0, 0, 0, 0, 6'h00, 32'h0, 32'h0);
        i_id_pc = 32'h40;
        #3;
        total++;
        if (o_id_pred_idx !== 6'h1B || int'(o_id_pred_idx) != exp_idx(32'h40)) begin
            bad++; $display("FAIL history_idx got=%h want=1b", o_id_pred_idx);
        end
        $display("history: idx=%h", o_id_pred_idx);
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            i_id_pc    = $urandom;
            i_id_is_br = 1'($urandom_range(0, 3) != 0);
            drive_ex(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                     1'($urandom), 1'($urandom), 6'($urandom_range(0, 7)),
                     $urandom, $urandom);
            if (n == 50) i_ex_pc = 32'hFFFF_FFFC;
            #3;
            total++;
            if (int'(o_id_pred_idx) != exp_idx(i_id_pc) || o_is_pred_need_br !== exp_pred(i_id_pc, i_id_is_br)) begin
                bad++; $display("FAIL rand_lookup n=%0d got idx=%h pred=%0b want idx=%h pred=%0b",
                                n, o_id_pred_idx, o_is_pred_need_br, exp_idx(i_id_pc), exp_pred(i_id_pc, i_id_is_br));
            end
            total++;
            if (o_is_pred_wrong !== (i_ex_br_valid && i_ex_adv && (i_ex_taken != i_ex_pred_taken))
                || o_redirect_pc !== exp_redirect()) begin
                bad++; $display("FAIL rand_resolve n=%0d got wrong=%0b pc=%h want pc=%h",
                                n, o_is_pred_wrong, o_redirect_pc, exp_redirect());
            end
            total++;
            if (o_br_cnt !== 32'(m_br) || o_miss_cnt !== 32'(m_miss)) begin
                bad++; $display("FAIL rand_stats n=%0d got br=%0d miss=%0d want %0d/%0d",
                                n, o_br_cnt, o_miss_cnt, m_br, m_miss);
            end
            if (n % 50 == 0)
                $display("random %0d: idx=%h pred=%0b wrong=%0b br=%0d miss=%0d",
                         n, o_id_pred_idx, o_is_pred_need_br, o_is_pred_wrong, o_br_cnt, o_miss_cnt);
            tick();
        end
    endtask

    task automatic test_async_reset();
        int badidx;
        // Train a few entries taken so the reset has something to clear.
        for (int n = 0; n < 4; n++) begin
            drive_ex(1, 1, 1, 1, 6'(n), 32'h0, 32'h0);
            tick();
        end
        drive_ex(1, 0, 1, 0, 6'h01, 32'h0, 32'h0);
        #1;
        i_rst_n = 1'b0;
        model_reset();
        #1;
        total++;
        if (o_br_cnt !== 32'd0 || o_miss_cnt !== 32'd0) begin
            bad++; $display("FAIL areset_stats got br=%0d miss=%0d want 0/0", o_br_cnt, o_miss_cnt);
        end
        badidx = -1;
        i_id_is_br = 1'b1;
        for (int i = 0; i < 64; i++) begin
            i_id_pc = 32'(i << 2);
            #1;
            if ((o_id_pred_idx !== 6'(i) || o_is_pred_need_br !== 1'b0) && badidx < 0) badidx = i;
        end
        total++;
        if (badidx >= 0) begin
            bad++; $display("FAIL areset_table first bad entry=%0d want idx=entry pred=0", badidx);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        // One taken step from a weakly-not-taken reset value must flip to taken.
        drive_ex(1, 1, 1, 0, 6'h00, 32'h0, 32'h0);
        tick();
        drive_ex(0, 0, 0, 0, 6'h00, 32'h0, 32'h0);
        i_id_pc = 32'((0 ^ m_ghr) << 2);
        #3;
        total++;
        if (o_is_pred_need_br !== exp_pred(i_id_pc, 1'b1) || o_is_pred_need_br !== 1'b1) begin
            bad++; $display("FAIL areset_wnt got=%0b want=1", o_is_pred_need_br);
        end
        $display("async reset: br=%0d miss=%0d", o_br_cnt, o_miss_cnt);
        tick();
    endtask

    initial begin
        test_reset();
        test_training();
        test_mispredict();
        test_stall();
        test_history();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic conditional-branch predictor for the 5-stage RV32I pipeline. It looks up a gshare-indexed table of 2-bit saturating counters for the branch in ID and drives the hazard controller's "predict taken at ID" request. It resolves the carried prediction in EX and drives the hazard controller's "prediction wrong" request together with the corrected fetch PC. It also keeps branch and mispredict statistics.

## Interface
Parameters:
- INDEX_W, 6, log2 of table entries; index drawn from PC[INDEX_W+1:2]
- GHR_W, 4, global history bits; legal range 1..INDEX_W
- CNT_RST, 2'b01, counter reset value (weakly not-taken)

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_rst_n  in  1  reset; asynchronous, active-low
- i_id_pc  in  32  PC of the instruction in ID
- i_id_is_br  in  1  ID holds a conditional branch (B-type)
- o_is_pred_need_br  out  1  predict taken; feeds the hazard controller
- o_id_pred_idx  out  INDEX_W  table index used for this lookup; carried down ID/EX
- i_ex_br_valid  in  1  EX holds a valid (unflushed) conditional branch
- i_ex_adv  in  1  EX/MEM register enabled this cycle (EX result leaves EX)
- i_ex_taken  in  1  resolved branch outcome
- i_ex_pred_taken  in  1  prediction carried from ID
- i_ex_pred_idx  in  INDEX_W  index carried from ID
- i_ex_pc  in  32  PC of the branch in EX
- i_ex_target  in  32  computed branch target
- o_is_pred_wrong  out  1  mispredict; feeds the hazard controller
- o_redirect_pc  out  32  corrected fetch PC, valid while o_is_pred_wrong=1
- o_br_cnt  out  32  resolved branches
- o_miss_cnt  out  32  mispredicts

## Operation
Lookup (ID):
- idx = i_id_pc[INDEX_W+1:2] XOR zero-extend(ghr).
- o_id_pred_idx = idx. It is driven even when i_id_is_br=0.
- o_is_pred_need_br = i_id_is_br & cnt[idx][1].

Resolution (EX):
- upd = i_ex_br_valid & i_ex_adv.
- o_is_pred_wrong = upd & (i_ex_taken != i_ex_pred_taken).
- o_redirect_pc = i_ex_taken ? i_ex_target : i_ex_pc + 4. The add is 32-bit and wraps modulo 2^32.

Update, only when upd=1:
- cnt[i_ex_pred_idx] increments when taken and decrements when not taken, saturating at 2'b11 and 2'b00.
- ghr <= {ghr[GHR_W-2:0], i_ex_taken}. For GHR_W=1, ghr <= i_ex_taken.
- o_br_cnt += 1, saturating at 32'hFFFF_FFFF.
- o_miss_cnt += 1 when o_is_pred_wrong=1, saturating at 32'hFFFF_FFFF.

No update occurs when upd=0. This covers stalls and flushed bubbles, so a branch stalled in EX updates exactly once.

## Timing
- Lookup is combinational from registered state and is available in the same cycle as i_id_pc.
- Resolution outputs are combinational. The state update is visible one cycle after upd.
- Same-cycle read and write of the same entry: the lookup returns the pre-update value. The GHR used for a lookup is likewise pre-update. There is no bypass.
- Mispredict while EX is stalled (i_ex_adv=0): o_is_pred_wrong stays 0 until the advance cycle, then asserts for exactly that one cycle.
- Reset (asynchronous, any time, including mid-stall):
  - all counters = CNT_RST, ghr = 0, o_br_cnt = 0, o_miss_cnt = 0;
  - o_is_pred_need_br and o_is_pred_wrong follow their inputs and registered state; with reset state they are 0 unless CNT_RST[1]=1.
- Release of reset takes effect on the next i_clk edge.

## Structure
- The shared package holds:
  - the 2-bit counter typedef;
  - the CNT_SNT/CNT_WNT/CNT_WT/CNT_ST constants;
  - the saturating-increment/decrement function.
- The counter table is a flop array. It uses asynchronous read and a single write port, which is required for asynchronous reset of every entry.
- One natural sub-module: sat_counter32, a 32-bit saturating event counter with enable and async reset. It is instantiated twice, for branches and for misses.
- GHR and index hashing stay in the top level.

## Test plan
- Reset then lookup: i_id_is_br=1, i_id_pc=32'h100 -> o_is_pred_need_br=0 and o_id_pred_idx=6'h00.
- Training:
  - three consecutive resolutions, taken, with i_ex_pred_idx=6'h05 and upd=1 -> cnt[5] goes 01→10→11→11 (saturates);
  - then a lookup hitting idx 5 -> o_is_pred_need_br=1.
- Not-taken mispredict: i_ex_pred_taken=1, i_ex_taken=0, i_ex_pc=32'h200, upd=1 -> o_is_pred_wrong=1, o_redirect_pc=32'h204, o_miss_cnt increments by 1.
- Stall hold:
  - mispredict (i_ex_pred_taken=0, i_ex_taken=1, i_ex_target=32'h80) held 3 cycles with i_ex_adv=0, then 1 cycle with i_ex_adv=1;
  - -> o_is_pred_wrong is low for 3 cycles, then high for 1 cycle, with redirect 32'h80;
  - -> o_br_cnt increments by 1 only.
- History: after taken, not-taken, taken, taken (GHR_W=4, ghr=4'b1011), lookup with i_id_pc=32'h40 -> o_id_pred_idx=6'h10^6'h0B=6'h1B.
- Async reset asserted mid-cycle after training -> every counter returns to 01, ghr=0, and both statistics are 0 immediately, without waiting for a clock edge.
